// File: rtl/rv64_pkg.sv
// Shared RV64I datapath types: fetch queue entry, fetch FSM states and PC helpers.
package rv64_pkg;

    localparam int XLEN = 64;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            misalign;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        IF_RUN  = 1'b0,
        IF_TRAP = 1'b1
    } if_state_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & {{(XLEN-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_unit_sync_fifo.sv
// Generic synchronous FIFO with push/pop/clear, occupancy count and register-driven head.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    wr_idx;
    logic             do_push, do_pop;

    // A clear may coincide with a push; the pushed word becomes the only entry.
    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
        wr_idx   = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            do_push  = push_i;
            wr_idx   = '0;
            rd_ptr_d = '0;
            wr_ptr_d = push_i ? AW'(1) : '0;
            count_d  = push_i ? CW'(1) : '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_idx] <= data_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch_unit.sv
// RV64I fetch stage: PC, single outstanding imem request, prefetch queue to decode.
// Define IFETCH_MISALIGN_CHK_EN to trap misaligned redirect targets.
module ifetch_unit
    import rv64_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_en,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc,
    input  logic        id_ready,
    input  logic        redir_valid,
    input  logic [63:0] redir_pc,
    output logic        if_misalign,
    output if_state_t   dbg_state_o
);

    localparam int CW = $clog2(QDEPTH) + 1;

    // Handshake: the head transfers on any cycle with if_valid & id_ready, unless a redirect flushes it.
    if_state_t    state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [63:0]  req_pc_q, req_pc_d;
    logic         inflight_q, inflight_d;

    logic [CW-1:0] q_count;
    logic [CW:0]   credit_used;
    logic          q_push, q_pop, q_clear;
    fetch_entry_t  push_entry, q_head;
    logic          redir_mis;

`ifdef IFETCH_MISALIGN_CHK_EN
    assign redir_mis   = redir_valid && (redir_pc[1:0] != 2'b00);
    assign if_misalign = if_valid & q_head.misalign;
`else
    assign redir_mis   = 1'b0;
    assign if_misalign = 1'b0;
`endif

    assign credit_used = {1'b0, q_count} + (CW+1)'(inflight_q);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        imem_en    = 1'b0;
        q_push     = 1'b0;
        q_pop      = 1'b0;
        q_clear    = 1'b0;
        push_entry = '{pc: req_pc_q, instr: imem_rdata, misalign: 1'b0};

        if ((state_q == IF_RUN) && !rst && !redir_valid && (credit_used < (CW+1)'(QDEPTH)))
            imem_en = 1'b1;

        if (imem_en) begin
            pc_d       = pc_q + 64'd4;
            req_pc_d   = pc_q;
            inflight_d = 1'b1;
        end

        if (redir_valid) begin
            q_clear = 1'b1;
            pc_d    = align_word(redir_pc);
            if (redir_mis) begin
                state_d    = IF_TRAP;
                q_push     = 1'b1;
                push_entry = '{pc: redir_pc, instr: NOP_INSTR, misalign: 1'b1};
            end else begin
                state_d = IF_RUN;
            end
        end else begin
            // The trap marker stays at the head until a redirect replaces it.
            q_pop  = if_valid && id_ready && !q_head.misalign;
            q_push = inflight_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IF_RUN;
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (q_clear),
        .push_i  (q_push),
        .data_i  (push_entry),
        .pop_i   (q_pop),
        .count_o (q_count),
        .head_o  (q_head)
    );

    assign imem_addr   = pc_q;
    assign if_valid    = (q_count != '0);
    assign if_instr    = q_head.instr;
    assign if_pc       = q_head.pc;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit against a queue-based reference model.
module tb_ifetch_unit;

    localparam logic [63:0] RESET_PC = 64'h0;
    localparam int          QDEPTH   = 4;

    logic        clk;
    logic        rst;
    logic        imem_en;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        id_ready;
    logic        redir_valid;
    logic [63:0] redir_pc;
    logic        if_misalign;
    rv64_pkg::if_state_t dbg_state;

    ifetch_unit #(
        .RESET_PC (RESET_PC),
        .QDEPTH   (QDEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .id_ready    (id_ready),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .if_misalign (if_misalign),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        mis;
    } ent_t;

    int          n_checks;
    int          n_errors;
    ent_t        exp_q[$];
    logic [63:0] m_pc;
    logic [63:0] m_infl_pc;
    int          m_infl;
    logic        m_trap;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[33:2] * 32'h9E37_79B1) ^ a[63:32];
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs at negedge, advance the model at posedge.
    task automatic step(input logic r, input logic rdy, input logic rv, input logic [63:0] rpc);
        logic        exp_en, exp_valid, en_s;
        logic [63:0] addr_s;
        rst = r; id_ready = rdy; redir_valid = rv; redir_pc = rpc;
        exp_en    = !r && !m_trap && !rv && ((exp_q.size() + m_infl) < QDEPTH);
        exp_valid = (exp_q.size() != 0);

        @(negedge clk);
        check_eq("imem_en", imem_en, exp_en);
        if (exp_en) check_eq("imem_addr", imem_addr, m_pc);
        check_eq("if_valid", if_valid, exp_valid);
        if (exp_valid) begin
            check_eq("if_pc", if_pc, exp_q[0].pc);
            check_eq("if_instr", if_instr, exp_q[0].instr);
        end
        check_eq("if_misalign", if_misalign, exp_valid && exp_q[0].mis);
        en_s   = imem_en;
        addr_s = imem_addr;

        @(posedge clk);
        if (r) begin
            m_pc = RESET_PC; m_infl = 0; m_trap = 1'b0; exp_q.delete();
        end else if (rv) begin
            exp_q.delete();
            m_infl = 0;
            m_pc   = {rpc[63:2], 2'b00};
            m_trap = 1'b0;
`ifdef IFETCH_MISALIGN_CHK_EN
            if (rpc[1:0] != 2'b00) begin
                m_trap = 1'b1;
                exp_q.push_back('{rpc, 32'h0000_0013, 1'b1});
            end
`endif
        end else begin
            if (exp_valid && rdy && !exp_q[0].mis) void'(exp_q.pop_front());
            if (m_infl != 0) exp_q.push_back('{m_infl_pc, mem_word(m_infl_pc), 1'b0});
            m_infl = exp_en ? 1 : 0;
            if (exp_en) begin
                m_infl_pc = m_pc;
                m_pc      = m_pc + 64'd4;
            end
        end
        #1;
        imem_rdata = en_s ? mem_word(addr_s) : $urandom();
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, rdy, 1'b0, 64'h0);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rst = 1'b1; id_ready = 1'b0; redir_valid = 1'b0; redir_pc = '0; imem_rdata = '0;
        m_pc = RESET_PC; m_infl = 0; m_infl_pc = '0; m_trap = 1'b0;
        @(posedge clk); #1;

        step(1'b1, 1'b0, 1'b0, 64'h0);
        step(1'b1, 1'b1, 1'b0, 64'h0);
        run(12, 1'b1);

        step(1'b1, 1'b0, 1'b0, 64'h0);
        run(8, 1'b0);
        run(8, 1'b1);

        step(1'b1, 1'b0, 1'b0, 64'h0);
        run(4, 1'b0);
        step(1'b0, 1'b0, 1'b1, 64'h40);
        run(6, 1'b1);

        run(5, 1'b1);
        step(1'b0, 1'b1, 1'b1, 64'h100);
        run(5, 1'b1);

        step(1'b0, 1'b1, 1'b1, 64'h42);
        run(4, 1'b1);
        step(1'b0, 1'b1, 1'b1, 64'h80);
        run(6, 1'b1);

        run(3, 1'b0);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        run(5, 1'b1);

        step(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        run(6, 1'b1);

        for (int i = 0; i < 800; i++) begin
            logic        r, rv, rdy;
            logic [63:0] rpc;
            r   = ($urandom_range(99) == 0);
            rv  = ($urandom_range(19) == 0);
            rdy = ($urandom_range(9) < 7);
            rpc = {$urandom(), $urandom()};
            if ($urandom_range(1) == 0) rpc[1:0] = 2'b00;
            step(r, rdy, rv, rpc);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage of the RV64I pipelined datapath. It sits directly upstream of decode. It owns the PC, issues sequential word fetches to the synchronous instruction memory, and buffers returned instructions in a small prefetch queue. Decode drains that queue through a valid/ready handshake. A taken branch or jump resolved in EX redirects the unit and flushes everything fetched after it.

## Interface
Parameters:
- RESET_PC, 64'h0, PC of the first fetch after reset
- QDEPTH, 4, prefetch queue entries; power of two, ≥2

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_en  out  1  fetch request this cycle
- imem_addr  out  64  byte address of the fetch; always 4-byte aligned
- imem_rdata  in  32  instruction; valid the cycle after imem_en=1 (fixed 1-cycle latency)
- if_valid  out  1  queue head holds an instruction for decode
- if_instr  out  32  instruction at queue head
- if_pc  out  64  PC of if_instr
- id_ready  in  1  decode accepts the head this cycle (deasserted by hazard stall)
- redir_valid  in  1  EX redirect (taken branch/jump)
- redir_pc  in  64  redirect target
- if_misalign  out  1  head entry is a misaligned-target trap marker (tied 0 when the check is compiled out)

## Operation
- Queue transfer happens when if_valid & id_ready → head is popped.
- Issue rule: imem_en=1 iff state=RUN, rst=0, redir_valid=0, and (queue count + inflight) < QDEPTH. inflight is 0 or 1 and equals the previous cycle's imem_en.
- On issue, imem_addr=pc and pc ← pc+4 (64-bit wrap, no exception).
- Response cycle (inflight=1, no redirect this cycle): {pc_of_req, imem_rdata} is pushed to the queue tail.
- Push and pop in the same cycle are both honoured. The credit rule makes overflow impossible. Popping an empty queue is a no-op.
- Redirect (redir_valid=1) has the highest priority:
  - queue is cleared; a pop in that cycle is discarded
  - the in-flight response is dropped; imem_en=0 that cycle
  - pc ← {redir_pc[63:2],2'b00}
- State machine:
  - RUN: normal operation.
  - TRAP: entered on a misaligned redirect when IFETCH_MISALIGN_CHK_EN is defined. No issues occur. The queue holds one marker entry: instr=32'h00000013, pc=redir_pc, if_misalign=1. The marker is not removed by pops.
  - TRAP → RUN on the next aligned redirect. A misaligned redirect while in TRAP replaces the marker.
- Reset values: pc=RESET_PC, queue empty, inflight=0, state=RUN, if_valid=0, imem_en=0, if_misalign=0. if_instr and if_pc are don't-care while if_valid=0.
- Reset mid-operation: all of the above apply on that edge; the pending response is ignored.

## Timing
- Issue in cycle N → data at imem_rdata in N+1 → entry in queue at edge ending N+1 → if_valid=1 in N+2. Fetch-to-decode latency is 2 cycles.
- First imem_en is in the first cycle with rst=0, with imem_addr=RESET_PC.
- Redirect in cycle R → imem_en=0 in R. In R+1, imem_en=1 with imem_addr=redir_pc. In R+3, if_valid=1 with if_pc=redir_pc.
- Steady-state throughput is 1 instruction/cycle when id_ready=1 continuously.
- The queue head is driven from registers; there is no combinational path from imem_rdata to if_*.
- id_ready and redir_valid have combinational paths only into imem_en and next-state logic.

## Configuration
- IFETCH_MISALIGN_CHK_EN defined:
  - a redir_pc with [1:0]≠0 enters TRAP as described above
  - if_misalign is driven by the marker entry
- Undefined:
  - redir_pc[1:0] is ignored (forced to 00)
  - TRAP is unreachable
  - if_misalign is constant 0

## Structure
- rv64_pkg holds:
  - XLEN=64
  - NOP_INSTR=32'h00000013
  - typedef fetch_entry_t {logic [63:0] pc; logic [31:0] instr; logic misalign;}
  - typedef enum if_state_t {IF_RUN, IF_TRAP}
- Sub-module sync_fifo, parameterised on width and depth, with push/pop/clear, count, and registered head output. It is reusable by later buffers.
- ifetch_unit contains the PC, the inflight bit, the FSM, and the credit logic.

## Test plan
- Reset, then id_ready=1 → imem_addr 0,4,8,… from cycle 0; if_valid first at cycle 2 with if_pc=0; consecutive if_pc=0,4,8, one per cycle.
- id_ready=0 for 8 cycles after reset:
  - imem_en drops after 4 issues (QDEPTH=4)
  - on release, if_pc=0,4,8,12,16 in order, none lost or duplicated
- Redirect to 0x40 in a cycle with inflight=1 and 3 queued entries:
  - next imem_addr=0x40
  - stale entries never appear
  - next valid if_pc=0x40
- Redirect concurrent with if_valid&id_ready → popped head discarded; no entry from before the redirect is presented afterwards.
- With IFETCH_MISALIGN_CHK_EN, redirect to 0x42:
  - imem_en stays 0
  - if_valid=1, if_misalign=1, if_instr=0x00000013, if_pc=0x42 persistently
  - a subsequent redirect to 0x80 resumes fetch at 0x80
- rst asserted mid-stream with a queued entry and inflight=1 → next cycle if_valid=0, imem_en=1 at RESET_PC; the old response is never pushed.
